// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 address sequencer: opcodes, FSM states,
// EAB select encodings and the EAB select decode.
package lc3_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic       SEL1_PC    = 1'b0;
    localparam logic       SEL1_BASE  = 1'b1;
    localparam logic [1:0] SEL2_ZERO  = 2'b00;
    localparam logic [1:0] SEL2_OFF11 = 2'b01;
    localparam logic [1:0] SEL2_OFF9  = 2'b10;
    localparam logic [1:0] SEL2_OFF6  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_READ, S_INDIR, S_WRITE, S_WB, S_DONE
    } state_e;

    typedef struct packed {
        logic       sel1;
        logic [1:0] sel2;
    } eab_sel_t;

    // op5 is ir[15:11]; bit 0 distinguishes JSR (PC-relative) from JSRR.
    function automatic eab_sel_t eab_decode(input logic [4:0] op5);
        eab_sel_t s;
        s.sel1 = SEL1_PC;
        s.sel2 = SEL2_ZERO;
        case (op5[4:1])
            OP_LD, OP_LDI, OP_ST, OP_STI, OP_LEA, OP_BR: begin
                s.sel1 = SEL1_PC;
                s.sel2 = SEL2_OFF9;
            end
            OP_LDR, OP_STR: begin
                s.sel1 = SEL1_BASE;
                s.sel2 = SEL2_OFF6;
            end
            OP_JSR: begin
                if (op5[0]) begin
                    s.sel1 = SEL1_PC;
                    s.sel2 = SEL2_OFF11;
                end else begin
                    s.sel1 = SEL1_BASE;
                    s.sel2 = SEL2_ZERO;
                end
            end
            default: begin
                s.sel1 = SEL1_PC;
                s.sel2 = SEL2_ZERO;
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lc3_addr_sequencer_mem_wait_timer.sv
// Per-access memory wait counter; saturates at TIMEOUT-1, never expires when TIMEOUT is 0.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int          W       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LIMIT   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, then saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT_W)) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == LIMIT_W);

endmodule

// File: rtl/lc3_addr_sequencer.sv
// Sequences the EAB selects and MAR/MDR/memory/write-back enables for the
// LC-3 address-forming instructions, reporting done/err per instruction.
module lc3_addr_sequencer
    import lc3_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [15:0] ir_i,
    input  logic        br_taken_i,
    input  logic        mem_ready_i,
    output logic        sel_eab1_o,
    output logic [1:0]  sel_eab2_o,
    output logic        ld_mar_o,
    output logic        mar_src_mdr_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic        ld_mdr_o,
    output logic        ld_reg_o,
    output logic        ld_pc_o,
    output logic        ld_r7_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        indirect_q, indirect_d;
    logic        err_q, err_d;
    logic [3:0]  opc_s;
    logic        op_legal_s;
    logic        expired_s;
    logic        tmo_s;
    eab_sel_t    sel_s;
    logic        unused_ir_s;

    assign opc_s       = ir_q[15:12];
    assign sel_s       = eab_decode(ir_q[15:11]);
    assign unused_ir_s = ^ir_q[10:0];
    assign tmo_s       = expired_s && !mem_ready_i;

    always_comb begin
        case (opc_s)
            OP_BR, OP_LD, OP_ST, OP_JSR, OP_LDR,
            OP_STR, OP_LDI, OP_STI, OP_LEA: op_legal_s = 1'b1;
            default:                        op_legal_s = 1'b0;
        endcase
    end

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!((state_q == S_READ) || (state_q == S_WRITE))),
        .en_i      (!mem_ready_i),
        .expired_o (expired_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_ADDR;
                else         state_d = S_IDLE;
            end
            S_ADDR: begin
                case (opc_s)
                    OP_LD, OP_LDR, OP_LDI, OP_STI: state_d = S_READ;
                    OP_ST, OP_STR:                 state_d = S_WRITE;
                    default:                       state_d = S_DONE;
                endcase
            end
            S_READ: begin
                if (mem_ready_i) state_d = indirect_q ? S_INDIR : S_WB;
                else if (tmo_s)  state_d = S_DONE;
                else             state_d = S_READ;
            end
            S_INDIR: state_d = (opc_s == OP_STI) ? S_WRITE : S_READ;
            S_WRITE: begin
                if (mem_ready_i || tmo_s) state_d = S_DONE;
                else                      state_d = S_WRITE;
            end
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Instruction, indirect and error flags next values.
    always_comb begin
        ir_d       = ir_q;
        indirect_d = indirect_q;
        err_d      = err_q;
        if ((state_q == S_IDLE) && start_i) begin
            ir_d       = ir_i;
            indirect_d = (ir_i[15:12] == OP_LDI) || (ir_i[15:12] == OP_STI);
            err_d      = 1'b0;
        end else if ((state_q == S_ADDR) && !op_legal_s) begin
            err_d = 1'b1;
        end else if (((state_q == S_READ) || (state_q == S_WRITE)) && tmo_s) begin
            err_d = 1'b1;
        end else if (state_q == S_INDIR) begin
            indirect_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q       <= 16'h0000;
            indirect_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            indirect_q <= indirect_d;
            err_q      <= err_d;
        end
    end

    // Moore output decode; ld_mdr and BR's ld_pc additionally follow their inputs.
    always_comb begin
        sel_eab1_o    = 1'b0;
        sel_eab2_o    = 2'b00;
        ld_mar_o      = 1'b0;
        mar_src_mdr_o = 1'b0;
        mem_en_o      = 1'b0;
        mem_we_o      = 1'b0;
        ld_mdr_o      = 1'b0;
        ld_reg_o      = 1'b0;
        ld_pc_o       = 1'b0;
        ld_r7_o       = 1'b0;
        done_o        = 1'b0;
        err_o         = 1'b0;
        busy_o        = (state_q != S_IDLE);
        if (state_q != S_IDLE) begin
            sel_eab1_o = sel_s.sel1;
            sel_eab2_o = sel_s.sel2;
        end else begin
            sel_eab1_o = 1'b0;
            sel_eab2_o = 2'b00;
        end
        case (state_q)
            S_ADDR: begin
                case (opc_s)
                    OP_LD, OP_LDR, OP_LDI,
                    OP_ST, OP_STR, OP_STI: ld_mar_o = 1'b1;
                    OP_LEA:                ld_reg_o = 1'b1;
                    OP_BR:                 ld_pc_o  = br_taken_i;
                    OP_JSR: begin
                        ld_pc_o = 1'b1;
                        ld_r7_o = 1'b1;
                    end
                    default:               ld_mar_o = 1'b0;
                endcase
            end
            S_READ: begin
                mem_en_o = 1'b1;
                ld_mdr_o = mem_ready_i;
            end
            S_INDIR: begin
                ld_mar_o      = 1'b1;
                mar_src_mdr_o = 1'b1;
            end
            S_WRITE: begin
                mem_en_o = 1'b1;
                mem_we_o = 1'b1;
            end
            S_WB:    ld_reg_o = 1'b1;
            S_DONE: begin
                done_o = 1'b1;
                err_o  = err_q;
            end
            default: done_o = 1'b0;
        endcase
    end

endmodule

// File: doc/lc3_addr_sequencer.md
# lc3_addr_sequencer

Multi-cycle controller that sequences the LC-3 effective-address datapath (EAB) and the memory interface for address-forming instructions: LD, LDI, LDR, LEA, ST, STI, STR, BR, JSR/JSRR. It captures the instruction on `start` and drives the EAB selects (`sel_eab1` for base, `sel_eab2` for offset width). It then steps through the MAR/MDR/memory/write-back sequence and reports `done`, or `err` on an illegal opcode or memory timeout. It sits between the main decode FSM and the EAB/MAR/MDR/register-file enables.

## Interface
- `TIMEOUT`, 16: maximum cycles spent waiting on `mem_ready` per access; 0 disables the timeout.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `ir`  in  16  instruction; captured into `ir_q` when `start` is accepted.
- `br_taken`  in  1  NZP match for BR; sampled in ADDR.
- `mem_ready`  in  1  memory completes the current access.
- `sel_eab1`  out  1  1 = base register (Ra), 0 = PC.
- `sel_eab2`  out  2  00 = zero, 01 = off11, 10 = off9, 11 = off6.
- `ld_mar`  out  1  MAR load.
- `mar_src_mdr`  out  1  1 = MAR takes MDR (indirect), 0 = MAR takes eabOut.
- `mem_en`  out  1  memory access active.
- `mem_we`  out  1  write when 1; valid only while `mem_en` = 1.
- `ld_mdr`  out  1  MDR load from memory.
- `ld_reg`  out  1  DR write (MDR for loads, eabOut for LEA).
- `ld_pc`  out  1  PC load from eabOut.
- `ld_r7`  out  1  R7 <= PC (JSR/JSRR).
- `busy`  out  1  high from accepted `start` until the cycle after `done`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`: illegal opcode or timeout.

## Operation
- States: IDLE, ADDR, READ, INDIR, WRITE, WB, DONE.
- IDLE + `start`: capture `ir_q` and an `indirect` flag (LDI/STI), go to ADDR. `start` while `busy` is ignored; the request is not queued.
- Selects are a pure decode of `ir_q[15:11]` and stay stable from ADDR through DONE.
  - LD/LDI/ST/STI/LEA/BR: sel1 = 0, sel2 = 10.
  - LDR/STR: sel1 = 1, sel2 = 11.
  - JSR (ir[11] = 1): sel1 = 0, sel2 = 01.
  - JSRR: sel1 = 1, sel2 = 00.
- ADDR (1 cycle):
  - Memory ops: `ld_mar` = 1 with `mar_src_mdr` = 0. Loads, LDI and STI go to READ; ST/STR go to WRITE.
  - LEA: `ld_reg` = 1, then DONE.
  - BR: `ld_pc` = `br_taken`, then DONE.
  - JSR/JSRR: `ld_r7` = `ld_pc` = 1 in the same cycle, then DONE.
  - Any other opcode: DONE with `err`.
- READ:
  - `mem_en` = 1 and `mem_we` = 0, held until `mem_ready`.
  - On the `mem_ready` cycle `ld_mdr` = 1.
  - Next state: INDIR if `indirect` is set, else WB.
- INDIR (1 cycle): `ld_mar` = 1, `mar_src_mdr` = 1, clear `indirect`.
  - LDI goes to READ.
  - STI goes to WRITE.
- WRITE: `mem_en` = `mem_we` = 1, held until `mem_ready`, then DONE.
- WB (1 cycle): `ld_reg` = 1, then DONE.
- DONE (1 cycle): `done` = 1, `err` per the latched error flag, then IDLE.
- Timeout:
  - Wait counter clears on entry to READ or WRITE and increments each cycle with `mem_ready` = 0.
  - If the counter reaches TIMEOUT-1 with `mem_ready` still 0 (TIMEOUT ≠ 0), drop `mem_en` and go to DONE with `err` = 1.
  - `mem_ready` arriving in that same cycle wins; no error.
- Reset: all outputs 0, state IDLE, `ir_q` and counter cleared. This applies immediately, including mid-access.

## Timing
- Control outputs are Moore-decoded from state and registered flags; `ld_mdr` is additionally gated by `mem_ready`.
- Latency from `start` to `done`, with memory ready in the first cycle of each access (N):
  - LEA/BR/JSR/illegal: 3.
  - ST/STR: 4.
  - LD/LDR: 5.
  - STI: 6.
  - LDI: 7.
  - Each wait cycle adds 1.
- `busy` = 1 in every non-IDLE state. Back-to-back `start` is accepted on the cycle after DONE.

## Structure
- Package `lc3_pkg`: opcode constants, state enum, `sel_eab2` encodings (SEL2_ZERO / OFF11 / OFF9 / OFF6), `sel_eab1` encodings.
- Sub-module `mem_wait_timer`: parameterised wait counter with clear/enable/expired.
- FSM, decode and output logic live in `lc3_addr_sequencer`.

## Test plan
- LD `ir` = 16'h2405, `mem_ready` always 1 -> ADDR sel = 0/10 with `ld_mar`; READ `ld_mdr`; WB `ld_reg`; `done` at cycle 5, `err` = 0.
- LDI 16'hA1FF, `mem_ready` delayed 2 cycles on each access -> two READ phases, INDIR with `mar_src_mdr` = 1, `done` at cycle 11.
- STR 16'h7A42 -> sel = 1/11, WRITE with `mem_we` = 1, no `ld_reg`, `done` at cycle 4.
- JSRR 16'h4080 then JSR 16'h4FFF -> sel = 1/00 then 0/01; `ld_r7` and `ld_pc` asserted together in ADDR.
- TIMEOUT = 4, ST with `mem_ready` stuck at 0 -> `mem_en` high for exactly 4 cycles, then `done` = `err` = 1; illegal opcode 16'h8000 -> `done` = `err` = 1 at cycle 3.
- `start` pulsed while busy -> ignored. `rst_n` asserted mid-READ -> all outputs 0 immediately, IDLE, next `start` behaves normally.
